// File: rtl/mul_acc_seq_pkg.sv
// Shared definitions for the multiply-accumulate peripheral and its divider partner.
package mul_acc_seq_pkg;

  localparam int unsigned MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_acc_seq_if.sv
// Start/busy/done handshake and operand/result bus of the multiply-accumulate unit.
interface mul_acc_seq_if #(
  parameter int unsigned WIDTH = mul_acc_seq_pkg::MUL_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   addend;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, product
  );

endinterface

// File: rtl/mul_acc_seq.sv
// Radix-2 shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Fixed latency of WIDTH iterations; result held until the next operation completes.
module mul_acc_seq
  import mul_acc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_acc_seq_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [PW-1:0]   acc_sum;
  logic            last_iter;
  logic            load;

  always_comb begin
    acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_iter = (count_q == CW'(WIDTH - 1));
    // Requests are taken in IDLE and in the DONE cycle, never while running.
    load      = bus.start && (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    if (load) begin
      acc_d    = PW'(bus.addend);
      mcand_d  = PW'(bus.multiplicand);
      mplier_d = bus.multiplier;
      count_d  = '0;
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      // The final partial product must land in the result on the way into DONE.
      if (last_iter) begin
        product_d = acc_sum;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_acc_seq.sv
// Directed bench for mul_acc_seq: timing, extremes, divider inverse, handshake and reset.
module tb_mul_acc_seq;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mul_acc_seq_if #(.WIDTH(W)) bus ();

  mul_acc_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is at cycle 0 (1 time unit after an edge); returns in the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [2*W-1:0] exp,
                        input string tag);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    for (int unsigned cyc = 1; cyc <= W; cyc++) begin
      step();
      if (cyc == 1) bus.start = 1'b0;
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "_nodone"}, 64'(bus.done), 64'd0);
    end
    step();
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    check({tag, "_prod"}, 64'(bus.product), 64'(exp));
  endtask

  initial begin
    logic [W-1:0]   dividend, divisor, quot, rem;
    logic [2*W-1:0] prev;
    logic           exp_done;
    logic [2*W-1:0] exp_prod;

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;

    step();
    step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", 64'(bus.product), 64'd0);
    rst_n = 1'b1;
    step();

    run_op(16'h1234, 16'h0010, 16'h0005, 32'h0001_2345, "basic");
    step();
    check("basic_after_busy", 64'(bus.busy), 64'd0);
    check("basic_after_done", 64'(bus.done), 64'd0);
    check("basic_hold", 64'(bus.product), 64'h0001_2345);

    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, "max");
    run_op(16'h0000, 16'hABCD, 16'h0000, 32'h0000_0000, "zero_a");
    run_op(16'h0000, 16'h0000, 16'h7777, 32'h0000_7777, "zero_ab");
    run_op(16'd142, 16'd7, 16'd6, 32'h0000_03E8, "div_inv");

    for (int i = 0; i < 200; i++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom_range(1, 65535));
      quot     = dividend / divisor;
      rem      = dividend % divisor;
      run_op(quot, divisor, rem, 32'(dividend), "sweep");
    end

    // start held high: results in cycles 17 and 34, then one more queued run.
    step();
    prev = 32'(dividend);
    bus.start        = 1'b1;
    bus.multiplicand = 16'd3;
    bus.multiplier   = 16'd4;
    bus.addend       = 16'd5;
    for (int unsigned cyc = 1; cyc <= 51; cyc++) begin
      step();
      if (cyc == 41) bus.start = 1'b0;
      exp_done = (cyc == 17) || (cyc == 34) || (cyc == 51);
      exp_prod = (cyc < 17) ? prev : (cyc < 34) ? 32'd17 : 32'd100;
      check("hold_done", 64'(bus.done), 64'(exp_done));
      check("hold_busy", 64'(bus.busy), 64'(!exp_done));
      check("hold_prod", 64'(bus.product), 64'(exp_prod));
      if (cyc == 17) begin
        bus.multiplicand = 16'd10;
        bus.multiplier   = 16'd10;
        bus.addend       = 16'd0;
      end
    end

    // start pulsed mid-run with different operands must be ignored.
    step();
    bus.start        = 1'b1;
    bus.multiplicand = 16'h0101;
    bus.multiplier   = 16'h0202;
    bus.addend       = 16'h0003;
    for (int unsigned cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 5) begin
        bus.start        = 1'b1;
        bus.multiplicand = 16'hFFFF;
        bus.multiplier   = 16'hFFFF;
        bus.addend       = 16'hFFFF;
      end
      if (cyc == 6) bus.start = 1'b0;
      if (cyc == 17) begin
        check("ign_done", 64'(bus.done), 64'd1);
        check("ign_prod", 64'(bus.product), 64'h0002_0405);
      end
      if (cyc > 17) begin
        check("ign_nodone", 64'(bus.done), 64'd0);
        check("ign_idle", 64'(bus.busy), 64'd0);
      end
    end

    // Asynchronous reset mid-run.
    bus.start        = 1'b1;
    bus.multiplicand = 16'h00FF;
    bus.multiplier   = 16'h00FF;
    bus.addend       = 16'h0001;
    for (int unsigned cyc = 1; cyc <= 6; cyc++) begin
      step();
      if (cyc == 1) bus.start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_prod", 64'(bus.product), 64'd0);
    for (int unsigned cyc = 0; cyc < 3; cyc++) begin
      step();
      check("in_rst_busy", 64'(bus.busy), 64'd0);
      check("in_rst_done", 64'(bus.done), 64'd0);
      check("in_rst_prod", 64'(bus.product), 64'd0);
    end
    rst_n = 1'b1;
    for (int unsigned cyc = 0; cyc < 20; cyc++) begin
      step();
      check("post_rst_done", 64'(bus.done), 64'd0);
      check("post_rst_prod", 64'(bus.product), 64'd0);
    end
    run_op(16'd3, 16'd5, 16'd1, 32'd16, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
